if_fetch_unit: RTL

Instruction-fetch front end of the five-stage MIPS-subset pipeline (ADDIU, LBU, BGTZ, SB, JAL, LUI, SUBU). It sits directly upstream of the ID stage and control unit:
- owns the PC/nPC register pair and drives the byte-addressed instruction memory;
- loads the IF/ID pipeline register;
- applies branch/jump targets from ID with one architectural delay slot;
- holds or queues a target while the hazard unit stalls.

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/ifid_reg.sv | 29 ++
 rtl/if_fetch_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the five-stage MIPS-subset pipeline front end.
//   fetch_state_t    : fetch FSM states (BOOT, RUN, HOLD_TGT)
//   INSTR_W          : instruction word width
//   NOP_WORD_DEFAULT : word placed in IF/ID when no valid fetch exists
//   ifid_t           : IF/ID pipeline register contents, also consumed by ID
//   word_align       : clears the two byte-offset bits of an address
package pipeline_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        HOLD_TGT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
        logic               valid;
    } ifid_t;

    function automatic logic [31:0] word_align(input logic [31:2] addr_hi);
        return {addr_hi, 2'b00};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg
// IF/ID pipeline register with load enable.
// Ports:
//   clk   : clock, rising-edge
//   reset : synchronous, active-low (0 = reset)
//   load  : capture d on this edge
//   d     : next IF/ID contents
//   q     : current IF/ID contents (reset to NOP_WORD, pc 0, not valid)
module ifid_reg
    import pipeline_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '{instr: NOP_WORD, pc: 32'h0, valid: 1'b0};
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch front end: PC/nPC pair, fetch FSM, IF/ID register.
// Branch/jump targets from ID redirect with one architectural delay slot;
// a target arriving while stalled is parked until the stall releases.
// Ports:
//   clk        : clock, rising-edge
//   reset      : synchronous, active-low (0 = reset)
//   stall      : hold PC, nPC and IF/ID this cycle
//   tgt_valid  : ID resolved a taken branch / jump this cycle
//   tgt_addr   : target address; low two bits are ignored
//   imem_addr  : instruction-memory byte address (low ADDR_W bits of pc)
//   imem_data  : big-endian word at imem_addr (combinational read)
//   pc, npc    : current and next fetch PC
//   ifid_instr, ifid_pc, ifid_valid : IF/ID register contents
// RESET_PC must be word-aligned.
module if_fetch_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 9,
    parameter logic [31:0]        RESET_PC = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               tgt_valid,
    input  logic [31:0]        tgt_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [31:0]        pc,
    output logic [31:0]        npc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [31:0]        ifid_pc,
    output logic               ifid_valid
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  npc_reg, npc_next;
    logic [31:0]  pend_reg, pend_next;

    logic         ifid_load;
    ifid_t        ifid_d;
    ifid_t        ifid_q;

    logic [31:0]  tgt_word;
    logic [1:0]   unused_tgt_bits;

    // Targets are always word addresses; the byte offset from ID is dropped.
    assign tgt_word        = word_align(tgt_addr[31:2]);
    assign unused_tgt_bits = tgt_addr[1:0];

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        npc_next   = npc_reg;
        pend_next  = pend_reg;
        ifid_load  = 1'b0;
        // Whatever sits at pc is what gets latched; on a redirect edge this
        // is the delay-slot instruction, which is never squashed.
        ifid_d     = '{instr: imem_data, pc: pc_reg, valid: 1'b1};

        case (state_reg)
            BOOT: begin
                // Single settling cycle; stall and tgt_valid are ignored.
                state_next = RUN;
            end
            RUN: begin
                if (!stall) begin
                    ifid_load = 1'b1;
                    if (tgt_valid) begin
                        pc_next  = tgt_word;
                        npc_next = tgt_word + 32'd4;
                    end else begin
                        pc_next  = npc_reg;
                        npc_next = npc_reg + 32'd4;
                    end
                end else if (tgt_valid) begin
                    pend_next  = tgt_word;
                    state_next = HOLD_TGT;
                end
            end
            HOLD_TGT: begin
                if (stall) begin
                    // Latest target wins while still stalled.
                    if (tgt_valid) begin
                        pend_next = tgt_word;
                    end
                end else begin
                    ifid_load  = 1'b1;
                    state_next = RUN;
                    if (tgt_valid) begin
                        pc_next  = tgt_word;
                        npc_next = tgt_word + 32'd4;
                    end else begin
                        pc_next  = pend_reg;
                        npc_next = pend_reg + 32'd4;
                    end
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_PC;
            npc_reg   <= RESET_PC + 32'd4;
            pend_reg  <= 32'h0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            npc_reg   <= npc_next;
            pend_reg  <= pend_next;
        end
    end

    ifid_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid_reg (
        .clk   (clk),
        .reset (reset),
        .load  (ifid_load),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_addr  = pc_reg[ADDR_W-1:0];
    assign pc         = pc_reg;
    assign npc        = npc_reg;
    assign ifid_instr = ifid_q.instr;
    assign ifid_pc    = ifid_q.pc;
    assign ifid_valid = ifid_q.valid;

endmodule
